sweep_ctrl: RTL and testbench

Sequencer for the 8-bit up/down counter datapath. It drives the counter's clear, enable and direction inputs and reads back the counter value. It runs a programmed triangular sweep: clear, preload to LO, count up to HI, dwell, count down to LO, dwell, repeated CYCLES times. A start/busy/done handshake serves a host FSM, with a stop abort.

---
 rtl/sweep_ctrl_pkg.sv | 26 ++
 rtl/sweep_ctrl_dwell_timer.sv | 28 ++
 rtl/sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_sweep_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl_pkg.sv
// Shared types and helpers for the triangular sweep sequencer.
package sweep_ctrl_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int CYC_W_DEF   = 4;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_PRELOAD  = 3'd2,
        ST_UP       = 3'd3,
        ST_DWELL_HI = 3'd4,
        ST_DOWN     = 3'd5,
        ST_DWELL_LO = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // A sweep needs a non-empty range and at least one repeat.
    function automatic logic cfg_ok(input logic [31:0] lo,
                                    input logic [31:0] hi,
                                    input logic [31:0] cycles);
        return (lo < hi) && (cycles != 32'd0);
    endfunction

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Down-counter that times the dwell at each turn of the sweep.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Sequencer driving an up/down counter through repeated lo..hi..lo triangles.
import sweep_ctrl_pkg::*;

module sweep_ctrl #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CYC_W   = CYC_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [CYC_W-1:0]   cycles,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WIDTH-1:0]   cnt_data,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic               cnt_up,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               aborted,
    output logic [CYC_W-1:0]   sweep_cnt
);

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     lo_reg, hi_reg;
    logic [CYC_W-1:0]     cycles_reg;
    logic [DWELL_W-1:0]   dwell_reg;
    logic [CYC_W-1:0]     sweep_cnt_reg;
    logic                 err_reg, aborted_reg;

    logic                 latch_cfg, accept, reject, sweep_inc;
    logic                 tmr_load, tmr_dec, tmr_zero;
    logic [DWELL_W-1:0]   tmr_val;

    // Dwell of zero behaves as one cycle, so the timer is loaded with D-1.
    assign tmr_val = (dwell_reg == '0) ? '0 : dwell_reg - DWELL_W'(1);
    assign tmr_dec = (state_reg == ST_DWELL_HI) || (state_reg == ST_DWELL_LO);

    dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state logic; stop in any busy state overrides every transition.
    always_comb begin
        state_next = state_reg;
        latch_cfg  = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        sweep_inc  = 1'b0;
        tmr_load   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !stop) begin
                    latch_cfg = 1'b1;
                    if (cfg_ok(32'(lo), 32'(hi), 32'(cycles))) begin
                        accept     = 1'b1;
                        state_next = ST_CLEAR;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_CLEAR:   state_next = ST_PRELOAD;
            ST_PRELOAD: if (cnt_data == lo_reg) state_next = ST_UP;
            ST_UP: begin
                if (cnt_data == hi_reg) begin
                    state_next = ST_DWELL_HI;
                    tmr_load   = 1'b1;
                end
            end
            ST_DWELL_HI: if (tmr_zero) state_next = ST_DOWN;
            ST_DOWN: begin
                if (cnt_data == lo_reg) begin
                    state_next = ST_DWELL_LO;
                    tmr_load   = 1'b1;
                end
            end
            ST_DWELL_LO: begin
                if (tmr_zero) begin
                    sweep_inc  = 1'b1;
                    state_next = (sweep_cnt_reg + CYC_W'(1) == cycles_reg) ? ST_DONE : ST_UP;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if ((state_reg != ST_IDLE) && stop) begin
            state_next = ST_IDLE;
            sweep_inc  = 1'b0;
            tmr_load   = 1'b0;
        end
    end

    // State, shadow configuration, sweep count and the registered pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= ST_IDLE;
            lo_reg        <= '0;
            hi_reg        <= '0;
            cycles_reg    <= '0;
            dwell_reg     <= '0;
            sweep_cnt_reg <= '0;
            err_reg       <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (latch_cfg) begin
                lo_reg     <= lo;
                hi_reg     <= hi;
                cycles_reg <= cycles;
                dwell_reg  <= dwell;
            end
            if (accept) begin
                sweep_cnt_reg <= '0;
            end else if (sweep_inc) begin
                sweep_cnt_reg <= sweep_cnt_reg + CYC_W'(1);
            end
            err_reg     <= reject;
            aborted_reg <= (state_reg != ST_IDLE) && stop;
        end
    end

    // Counter drive: enable drops the moment the target is reached or stop is seen.
    always_comb begin
        cnt_en = 1'b0;
        if (!clr && !stop) begin
            case (state_reg)
                ST_PRELOAD: cnt_en = (cnt_data != lo_reg);
                ST_UP:      cnt_en = (cnt_data != hi_reg);
                ST_DOWN:    cnt_en = (cnt_data != lo_reg);
                default:    cnt_en = 1'b0;
            endcase
        end
    end

    assign cnt_clr   = clr || (state_reg == ST_CLEAR);
    assign cnt_up    = !clr && ((state_reg == ST_PRELOAD) || (state_reg == ST_UP));
    assign busy      = !clr && (state_reg != ST_IDLE);
    assign done      = !clr && !stop && (state_reg == ST_DONE);
    assign err       = err_reg;
    assign aborted   = aborted_reg;
    assign sweep_cnt = sweep_cnt_reg;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench: sweep_ctrl driving a behavioural up/down counter.
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, stop;
    logic [7:0] lo, hi, dwell;
    logic [3:0] cycles;
    logic [7:0] cnt_data;
    logic       cnt_clr, cnt_en, cnt_up, busy, done, err, aborted;
    logic [3:0] sweep_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        bit         chk_data;
        bit         done;
        bit         clr;
        logic [3:0] sweep;
    } exp_t;
    exp_t sbq[$];

    int done_cnt = 0;
    int busy_cnt = 0;
    int clr_cnt  = 0;

    always #5 clk = ~clk;

    sweep_ctrl dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop),
        .lo(lo), .hi(hi), .cycles(cycles), .dwell(dwell),
        .cnt_data(cnt_data), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .busy(busy), .done(done), .err(err), .aborted(aborted), .sweep_cnt(sweep_cnt)
    );

    // Existing 8-bit up/down counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (cnt_clr)     cnt_data <= 8'd0;
        else if (cnt_en) cnt_data <= cnt_up ? cnt_data + 8'd1 : cnt_data - 8'd1;
    end

    // Event monitor sampled mid-cycle after the bench has driven its inputs.
    always @(negedge clk) begin
        #2;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (cnt_clr === 1'b1 && clr === 1'b0) clr_cnt++;
    end

    task automatic push_traj(input int l, input int h, input int c, input int dw);
        int d;
        d = (dw == 0) ? 1 : dw;
        sbq.push_back('{data: 8'd0, chk_data: 1'b0, done: 1'b0, clr: 1'b1, sweep: 4'd0});
        for (int v = 0; v <= l; v++)
            sbq.push_back('{data: 8'(v), chk_data: 1'b1, done: 1'b0, clr: 1'b0, sweep: 4'd0});
        for (int s = 0; s < c; s++) begin
            for (int v = l; v <= h; v++)
                sbq.push_back('{data: 8'(v), chk_data: 1'b1, done: 1'b0, clr: 1'b0, sweep: 4'(s)});
            for (int i = 0; i < d; i++)
                sbq.push_back('{data: 8'(h), chk_data: 1'b1, done: 1'b0, clr: 1'b0, sweep: 4'(s)});
            for (int v = h; v >= l; v--)
                sbq.push_back('{data: 8'(v), chk_data: 1'b1, done: 1'b0, clr: 1'b0, sweep: 4'(s)});
            for (int i = 0; i < d; i++)
                sbq.push_back('{data: 8'(l), chk_data: 1'b1, done: 1'b0, clr: 1'b0, sweep: 4'(s)});
        end
        sbq.push_back('{data: 8'(l), chk_data: 1'b1, done: 1'b1, clr: 1'b0, sweep: 4'(c)});
    endtask

    // Full run checked cycle by cycle; poke=1 fires a second start mid-run.
    task automatic run_sweep(input int l, input int h, input int c, input int dw, input bit poke);
        exp_t e;
        int   k;
        @(negedge clk);
        lo = 8'(l); hi = 8'(h); cycles = 4'(c); dwell = 8'(dw); start = 1'b1;
        push_traj(l, h, c, dw);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (sbq.size() > 0) begin
            if (poke && k == 4) begin
                start = 1'b1; lo = 8'd0; hi = 8'd100; cycles = 4'd9; dwell = 8'd7;
            end
            if (poke && k == 5) start = 1'b0;
            #1;
            e = sbq.pop_front();
            if (e.chk_data) begin
                total++;
                if (cnt_data !== e.data) begin
                    bad++;
                    $display("FAIL run_data lo=%0d hi=%0d cyc=%0d: cycle %0d cnt_data=%0d expected %0d", l, h, c, k, cnt_data, e.data);
                end
            end
            total++;
            if (done !== e.done) begin
                bad++;
                $display("FAIL run_done lo=%0d hi=%0d: cycle %0d done=%b expected %b", l, h, k, done, e.done);
            end
            total++;
            if (cnt_clr !== e.clr) begin
                bad++;
                $display("FAIL run_cnt_clr lo=%0d hi=%0d: cycle %0d cnt_clr=%b expected %b", l, h, k, cnt_clr, e.clr);
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL run_busy lo=%0d hi=%0d: cycle %0d busy=%b expected 1", l, h, k, busy);
            end
            total++;
            if (sweep_cnt !== e.sweep) begin
                bad++;
                $display("FAIL run_sweep_cnt lo=%0d hi=%0d: cycle %0d sweep_cnt=%0d expected %0d", l, h, k, sweep_cnt, e.sweep);
            end
            k++;
            @(negedge clk);
        end
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 4'(c)) begin
            bad++;
            $display("FAIL run_end lo=%0d hi=%0d: busy=%b done=%b sweep_cnt=%0d expected 0 0 %0d", l, h, busy, done, sweep_cnt, c);
        end
        $display("run lo=%0d hi=%0d cycles=%0d dwell=%0d poke=%0d finished after %0d cycles", l, h, c, dw, poke, k - 1);
    endtask

    task automatic wait_val(input logic [7:0] v, input int lim, input string nm);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #1;
            if (cnt_data === v) begin
                total++;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: cnt_data=%0d never reached %0d within %0d cycles", nm, cnt_data, v, lim);
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; stop = 1'b0;
        lo = 8'd0; hi = 8'd0; cycles = 4'd0; dwell = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({cnt_clr, cnt_en, cnt_up, busy, done, err, aborted} !== 7'b1000000 || sweep_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_hold: clr/en/up/busy/done/err/abt=%b sweep=%0d expected 1000000 0",
                     {cnt_clr, cnt_en, cnt_up, busy, done, err, aborted}, sweep_cnt);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        total++;
        if (cnt_data !== 8'd0 || cnt_clr !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: cnt_data=%0d cnt_clr=%b busy=%b expected 0 0 0", cnt_data, cnt_clr, busy);
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        run_sweep(2, 5, 1, 1, 1'b0);
    endtask

    task automatic test_multi();
        run_sweep(0, 3, 3, 4, 1'b0);
    endtask

    task automatic test_bad_config();
        int b0, c0;
        b0 = busy_cnt; c0 = clr_cnt;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            if (t == 0) begin lo = 8'd7; hi = 8'd7; cycles = 4'd1; end
            else        begin lo = 8'd2; hi = 8'd5; cycles = 4'd0; end
            dwell = 8'd1; start = 1'b1;
            #1;
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL bad_cfg_early case %0d: err=%b expected 0", t, err);
            end
            @(negedge clk);
            start = 1'b0;
            #1;
            total++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL bad_cfg_pulse case %0d: err=%b busy=%b expected 1 0", t, err, busy);
            end
            @(negedge clk);
            #1;
            total++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL bad_cfg_after case %0d: err=%b busy=%b expected 0 0", t, err, busy);
            end
            $display("bad config case %0d checked", t);
        end
        @(negedge clk);
        total++;
        if (busy_cnt != b0 || clr_cnt != c0) begin
            bad++;
            $display("FAIL bad_cfg_quiet: busy cycles=%0d cnt_clr cycles=%0d expected 0 0", busy_cnt - b0, clr_cnt - c0);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        lo = 8'd2; hi = 8'd9; cycles = 4'd1; dwell = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_val(8'd4, 40, "abort_wait");
        stop = 1'b1;
        #1;
        total++;
        if (cnt_en !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL abort_same_cycle: cnt_en=%b done=%b aborted=%b expected 0 0 0", cnt_en, done, aborted);
        end
        @(negedge clk);
        stop = 1'b0;
        #1;
        total++;
        if (aborted !== 1'b1 || busy !== 1'b0 || cnt_data !== 8'd4) begin
            bad++;
            $display("FAIL abort_pulse: aborted=%b busy=%b cnt_data=%0d expected 1 0 4", aborted, busy, cnt_data);
        end
        @(negedge clk);
        #1;
        total++;
        if (aborted !== 1'b0 || cnt_data !== 8'd4) begin
            bad++;
            $display("FAIL abort_after: aborted=%b cnt_data=%0d expected 0 4", aborted, cnt_data);
        end
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL abort_no_done: done seen %0d times expected 0", done_cnt - d0);
        end
        $display("abort checked");
        run_sweep(2, 5, 1, 1, 1'b0);
    endtask

    task automatic test_clr_mid();
        @(negedge clk);
        lo = 8'd10; hi = 8'd250; cycles = 4'd1; dwell = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_val(8'd250, 400, "clr_wait_top");
        wait_val(8'd200, 100, "clr_wait_down");
        clr = 1'b1;
        #1;
        total++;
        if (cnt_clr !== 1'b1 || busy !== 1'b0 || cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL clr_mid_now: cnt_clr=%b busy=%b cnt_en=%b expected 1 0 0", cnt_clr, busy, cnt_en);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        total++;
        if ({cnt_en, cnt_up, busy, done, err, aborted} !== 6'b0 || cnt_data !== 8'd0 || sweep_cnt !== 4'd0) begin
            bad++;
            $display("FAIL clr_mid_after: en/up/busy/done/err/abt=%b cnt_data=%0d sweep=%0d expected 000000 0 0",
                     {cnt_en, cnt_up, busy, done, err, aborted}, cnt_data, sweep_cnt);
        end
        $display("clear mid-run checked");
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        lo = 8'd1; hi = 8'd4; cycles = 4'd1; dwell = 8'd1; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || err !== 1'b0 || aborted !== 1'b0 || cnt_clr !== 1'b0) begin
            bad++;
            $display("FAIL start_stop_idle: busy=%b err=%b aborted=%b cnt_clr=%b expected 0 0 0 0", busy, err, aborted, cnt_clr);
        end
        $display("start+stop in idle checked");
        run_sweep(1, 4, 2, 2, 1'b1);
        run_sweep(250, 255, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi();
        test_bad_config();
        test_abort();
        test_clr_mid();
        test_simultaneous();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
